// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Round-robin arbiter/sequencer sharing a single WIDTHxWIDTH multiplier among
//   N_REQ requesters. One requester is granted at a time, and its operands are
//   latched at the grant edge. The block runs the multiplier valid/ack
//   handshake and returns the captured product through a done/ack handshake.
//
// Ports
//   Clock, Reset          rising-edge clock, async active-high reset
//   iReq[N_REQ]           level requests
//   iData_A/B             packed operands, requester i at [i*WIDTH +: WIDTH]
//   iAck[N_REQ]           requester has consumed oResult (only owner's bit used)
//   oGrant[N_REQ]         one-hot current owner
//   oDone[N_REQ]          one-hot, oResult valid for owner
//   oResult               product of the last completed grant (sticky)
//   oBusy                 arbiter not in IDLE
//   oMult_A/B, oMult_Valid, oMult_Ack       to multiplier
//   iMult_Done, iMult_Idle, iMult_Result    from multiplier
module mult_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [N_REQ-1:0]       iReq,
    input  logic [N_REQ*WIDTH-1:0] iData_A,
    input  logic [N_REQ*WIDTH-1:0] iData_B,
    input  logic [N_REQ-1:0]       iAck,
    output logic [N_REQ-1:0]       oGrant,
    output logic [N_REQ-1:0]       oDone,
    output logic [2*WIDTH-1:0]     oResult,
    output logic                   oBusy,
    output logic [WIDTH-1:0]       oMult_A,
    output logic [WIDTH-1:0]       oMult_B,
    output logic                   oMult_Valid,
    output logic                   oMult_Ack,
    input  logic                   iMult_Done,
    input  logic                   iMult_Idle,
    input  logic [2*WIDTH-1:0]     iMult_Result
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, DELIVER, RELEASE} state_t;

    state_t        state;
    logic [PW-1:0] ptr;      // highest-priority requester for the next grant
    logic [PW-1:0] cur;      // index of the current owner
    logic [PW-1:0] sel;
    logic [PW-1:0] idx;
    logic          sel_vld;

    // Scan from ptr upward with wrap. Offsets are walked from the far end down
    // so the closest requester to ptr is the last one written and wins.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx = PW'((int'(ptr) + off) % N_REQ);
            if (iReq[idx]) begin
                sel     = idx;
                sel_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            ptr         <= '0;
            cur         <= '0;
            oGrant      <= '0;
            oDone       <= '0;
            oResult     <= '0;
            oBusy       <= 1'b0;
            oMult_A     <= '0;
            oMult_B     <= '0;
            oMult_Valid <= 1'b0;
            oMult_Ack   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iMult_Idle && sel_vld) begin
                        cur         <= sel;
                        oGrant      <= N_REQ'(1) << sel;
                        oMult_A     <= iData_A[int'(sel)*WIDTH +: WIDTH];
                        oMult_B     <= iData_B[int'(sel)*WIDTH +: WIDTH];
                        oMult_Valid <= 1'b1;
                        oBusy       <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                // Multiplier signals acceptance by leaving idle.
                ISSUE: begin
                    if (!iMult_Idle) begin
                        oMult_Valid <= 1'b0;
                        state       <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (iMult_Done) begin
                        oResult   <= iMult_Result;
                        oDone     <= oGrant;
                        oMult_Ack <= 1'b1;
                        state     <= DELIVER;
                    end
                end
                // Only the owner's ack bit is honoured.
                DELIVER: begin
                    if (|(iAck & oGrant)) begin
                        oDone <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!iMult_Done) begin
                        oMult_Ack <= 1'b0;
                        oGrant    <= '0;
                        ptr       <= (cur == PW'(N_REQ - 1)) ? '0 : cur + PW'(1);
                        oBusy     <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter
//   Directed bench for mult_arbiter (N_REQ=4, WIDTH=32) with a behavioural
//   multiplier model: it accepts when idle and valid, raises done after LAT
//   cycles, and drops done (returning to idle) once ack is seen.
module tb_mult_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 4;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic [N-1:0]     iReq = '0;
    logic [N*W-1:0]   iData_A = '0;
    logic [N*W-1:0]   iData_B = '0;
    logic [N-1:0]     iAck = '0;
    logic [N-1:0]     oGrant, oDone;
    logic [2*W-1:0]   oResult;
    logic             oBusy;
    logic [W-1:0]     oMult_A, oMult_B;
    logic             oMult_Valid, oMult_Ack;
    logic             m_done, m_idle;
    logic [2*W-1:0]   m_res;
    int               m_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int vld_rises = 0;
    int done_rises = 0;
    logic vld_prev = 1'b0;
    logic done_prev = 1'b0;

    always #5 Clock = ~Clock;

    mult_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset), .iReq(iReq), .iData_A(iData_A), .iData_B(iData_B),
        .iAck(iAck), .oGrant(oGrant), .oDone(oDone), .oResult(oResult), .oBusy(oBusy),
        .oMult_A(oMult_A), .oMult_B(oMult_B), .oMult_Valid(oMult_Valid), .oMult_Ack(oMult_Ack),
        .iMult_Done(m_done), .iMult_Idle(m_idle), .iMult_Result(m_res)
    );

    // Multiplier model
    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_idle <= 1'b1;
            m_done <= 1'b0;
            m_res  <= '0;
            m_cnt  <= 0;
        end else if (m_done) begin
            if (oMult_Ack) begin
                m_done <= 1'b0;
                m_idle <= 1'b1;
            end
        end else if (!m_idle) begin
            if (m_cnt == 1) m_done <= 1'b1;
            m_cnt <= m_cnt - 1;
        end else if (oMult_Valid) begin
            m_idle <= 1'b0;
            m_cnt  <= LAT;
            m_res  <= {32'b0, oMult_A} * {32'b0, oMult_B};
        end
    end

    // Edge counters for valid and done pulses
    always @(negedge Clock) begin
        if (oMult_Valid && !vld_prev) vld_rises <= vld_rises + 1;
        if ((oDone != 0) && !done_prev) done_rises <= done_rises + 1;
        vld_prev  <= oMult_Valid;
        done_prev <= (oDone != 0);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        iData_A[k*W +: W] = a;
        iData_B[k*W +: W] = b;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        iReq  = '0;
        iAck  = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (oGrant != 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (oDone != 0) begin ok = 1'b1; break; end
        end
    endtask

    // Ack requester k and wait for the arbiter to reach IDLE.
    task automatic finish_txn(input int k, output bit ok);
        iAck[k] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (!oBusy) begin ok = 1'b1; break; end
        end
        iAck = '0;
    endtask

    task automatic test_reset();
        bit all_zero;
        Reset = 1'b1;
        @(negedge Clock);
        all_zero = (oGrant == 0) && (oDone == 0) && (oResult == 0) && !oBusy &&
                   (oMult_A == 0) && (oMult_B == 0) && !oMult_Valid && !oMult_Ack;
        n_cmp++;
        if (all_zero !== 1'b1) begin
            n_err++;
            $display("FAIL reset_outputs: got grant=%b done=%b res=%h busy=%b, want all 0",
                     oGrant, oDone, oResult, oBusy);
        end
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        n_cmp++;
        if (oBusy !== 1'b0 || oGrant !== 4'b0) begin
            n_err++;
            $display("FAIL idle_no_req: got busy=%b grant=%b, want 0/0000", oBusy, oGrant);
        end
    endtask

    task automatic test_single();
        bit ok;
        int r0;
        do_reset();
        set_ops(0, 32'd3, 32'd5);
        r0 = vld_rises;
        iReq = 4'b0001;
        wait_grant(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL single_grant_timeout: got %b want 1", ok); end
        n_cmp++;
        if (oGrant !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", oGrant); end
        n_cmp++;
        if (oMult_A !== 32'd3 || oMult_B !== 32'd5) begin
            n_err++; $display("FAIL single_ops: got %0d,%0d want 3,5", oMult_A, oMult_B);
        end
        n_cmp++;
        if (oMult_Valid !== 1'b1 || oBusy !== 1'b1) begin
            n_err++; $display("FAIL single_valid_busy: got %b,%b want 1,1", oMult_Valid, oBusy);
        end
        wait_done(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL single_done_timeout: got %b want 1", ok); end
        n_cmp++;
        if (oDone !== 4'b0001 || oResult !== 64'd15) begin
            n_err++; $display("FAIL single_result: got done=%b res=%0d want 0001/15", oDone, oResult);
        end
        n_cmp++;
        if (oMult_Ack !== 1'b1) begin n_err++; $display("FAIL single_mult_ack: got %b want 1", oMult_Ack); end
        iReq = '0;
        finish_txn(0, ok);
        n_cmp++;
        if (ok !== 1'b1 || oDone !== 4'b0 || oGrant !== 4'b0 || oBusy !== 1'b0) begin
            n_err++; $display("FAIL single_release: got ok=%b done=%b grant=%b busy=%b want 1/0/0/0",
                              ok, oDone, oGrant, oBusy);
        end
        n_cmp++;
        if (vld_rises - r0 !== 1) begin
            n_err++; $display("FAIL single_valid_pulses: got %0d want 1", vld_rises - r0);
        end
        n_cmp++;
        if (oResult !== 64'd15) begin n_err++; $display("FAIL result_sticky: got %0d want 15", oResult); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int d0;
        logic [63:0] exp_res [4] = '{64'd2, 64'd6, 64'd12, 64'd20};
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, W'(i + 1), W'(i + 2));
        d0 = done_rises;
        iReq = 4'b1111;
        for (int t = 0; t < 4; t++) begin
            wait_done(ok);
            n_cmp++;
            if (ok !== 1'b1 || oDone !== 4'(1 << t) || oGrant !== 4'(1 << t)) begin
                n_err++; $display("FAIL rr_order[%0d]: got ok=%b done=%b grant=%b want done=grant=%b",
                                  t, ok, oDone, oGrant, 4'(1 << t));
            end
            n_cmp++;
            if (oResult !== exp_res[t]) begin
                n_err++; $display("FAIL rr_result[%0d]: got %0d want %0d", t, oResult, exp_res[t]);
            end
            if (t == 3) iReq = '0;
            finish_txn(t, ok);
        end
        n_cmp++;
        if (done_rises - d0 !== 4) begin
            n_err++; $display("FAIL rr_done_pulses: got %0d want 4", done_rises - d0);
        end
    endtask

    task automatic test_fairness();
        bit ok;
        int exp_k [6] = '{0, 2, 0, 2, 0, 2};
        logic [63:0] exp_res [6] = '{64'd14, 64'd27, 64'd14, 64'd27, 64'd14, 64'd27};
        do_reset();
        set_ops(0, 32'd7, 32'd2);
        set_ops(2, 32'd3, 32'd9);
        iReq = 4'b0101;
        for (int t = 0; t < 6; t++) begin
            wait_done(ok);
            n_cmp++;
            if (ok !== 1'b1 || oGrant !== 4'(1 << exp_k[t]) || oResult !== exp_res[t]) begin
                n_err++; $display("FAIL fair_seq[%0d]: got grant=%b res=%0d want %b/%0d",
                                  t, oGrant, oResult, 4'(1 << exp_k[t]), exp_res[t]);
            end
            if (t == 5) iReq = '0;
            finish_txn(exp_k[t], ok);
        end
    endtask

    task automatic test_delayed_ack();
        bit ok;
        int changes;
        logic [63:0] r0;
        do_reset();
        set_ops(1, 32'd6, 32'd7);
        set_ops(3, 32'd2, 32'd2);
        iReq = 4'b0010;
        wait_done(ok);
        n_cmp++;
        if (ok !== 1'b1 || oDone !== 4'b0010 || oResult !== 64'd42) begin
            n_err++; $display("FAIL delay_first: got done=%b res=%0d want 0010/42", oDone, oResult);
        end
        iReq = 4'b1010;
        // Non-owner ack must be ignored while we stall.
        iAck = 4'b1000;
        r0 = oResult;
        changes = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clock);
            if (oDone !== 4'b0010 || oResult !== r0 || oMult_Ack !== 1'b1 || oGrant !== 4'b0010)
                changes++;
        end
        iAck = '0;
        n_cmp++;
        if (changes !== 0) begin
            n_err++; $display("FAIL delay_hold: got %0d unstable cycles want 0", changes);
        end
        iReq = 4'b1000;
        finish_txn(1, ok);
        wait_done(ok);
        n_cmp++;
        if (ok !== 1'b1 || oDone !== 4'b1000 || oResult !== 64'd4) begin
            n_err++; $display("FAIL delay_next: got done=%b res=%0d want 1000/4", oDone, oResult);
        end
        iReq = '0;
        finish_txn(3, ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit all_zero;
        do_reset();
        // Serve requester 2 once so the pointer moves to 3.
        set_ops(2, 32'd10, 32'd10);
        iReq = 4'b0100;
        wait_done(ok);
        iReq = '0;
        finish_txn(2, ok);
        set_ops(2, 32'd11, 32'd11);
        iReq = 4'b0100;
        wait_grant(ok);
        for (int i = 0; i < 20; i++) begin
            if (!oMult_Valid) break;
            @(negedge Clock);
        end
        n_cmp++;
        if (oGrant !== 4'b0100 || oMult_Valid !== 1'b0 || oDone !== 4'b0) begin
            n_err++; $display("FAIL mid_wait_state: got grant=%b valid=%b done=%b want 0100/0/0000",
                              oGrant, oMult_Valid, oDone);
        end
        #1 Reset = 1'b1;
        #1;
        all_zero = (oGrant == 0) && (oDone == 0) && (oResult == 0) && !oBusy &&
                   (oMult_A == 0) && (oMult_B == 0) && !oMult_Valid && !oMult_Ack;
        n_cmp++;
        if (all_zero !== 1'b1) begin
            n_err++; $display("FAIL mid_async_reset: got grant=%b res=%h busy=%b want all 0",
                              oGrant, oResult, oBusy);
        end
        set_ops(0, 32'd4, 32'd4);
        set_ops(3, 32'd9, 32'd9);
        iReq = 4'b1001;
        @(negedge Clock);
        Reset = 1'b0;
        wait_done(ok);
        n_cmp++;
        if (ok !== 1'b1 || oDone !== 4'b0001 || oResult !== 64'd16) begin
            n_err++; $display("FAIL mid_ptr_zero: got done=%b res=%0d want 0001/16", oDone, oResult);
        end
        iReq = '0;
        finish_txn(0, ok);
    endtask

    task automatic test_max_operands();
        bit ok;
        do_reset();
        set_ops(2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        iReq = 4'b0100;
        wait_grant(ok);
        // Change operands and drop request after the grant edge.
        set_ops(2, 32'd0, 32'd5);
        iReq = '0;
        wait_done(ok);
        n_cmp++;
        if (ok !== 1'b1 || oDone !== 4'b0100 || oResult !== 64'hFFFFFFFE00000001) begin
            n_err++; $display("FAIL max_result: got done=%b res=%h want 0100/fffffffe00000001",
                              oDone, oResult);
        end
        n_cmp++;
        if (oMult_A !== 32'hFFFFFFFF) begin
            n_err++; $display("FAIL max_ops_held: got %h want ffffffff", oMult_A);
        end
        finish_txn(2, ok);
        n_cmp++;
        if (ok !== 1'b1 || oBusy !== 1'b0) begin
            n_err++; $display("FAIL max_release: got ok=%b busy=%b want 1/0", ok, oBusy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_delayed_ack();
        test_reset_mid();
        test_max_operands();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
